// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with operand forwarding, load-use stall and branch resolution
// Output register plus an EMPTY/FULL/KILL handshake FSM; KILL is the redirect cycle.
module decode_stage #(
    parameter int NUM_FWD = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic [31:0]           in_inst,
    output logic [9:0]            rf_raddr,
    input  logic [63:0]           rf_rdata,
    input  logic [NUM_FWD-1:0]    fwd_valid,
    input  logic [NUM_FWD-1:0]    fwd_pending,
    input  logic [5*NUM_FWD-1:0]  fwd_rd,
    input  logic [32*NUM_FWD-1:0] fwd_data,
    input  logic                  flush_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_imm,
    output logic [31:0]           out_op1,
    output logic [31:0]           out_op2,
    output logic [4:0]            out_rd,
    output logic                  out_wreg,
    output logic                  out_illegal,
    output logic                  br_valid,
    output logic [31:0]           br_target,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
        OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13, OP_OP = 7'h33,
        OP_FENCE = 7'h0f, OP_SYS = 7'h73;
    typedef enum logic [1:0] {EMPTY, FULL, KILL} state_t;
    state_t state, state_nxt;
    logic [6:0] opc, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm, op1, op2, target;
    logic use1, use2, wcls, legal, p1, p2, hazard, wreg, cond, taken, kill, accept;
    assign {f7, rs2, rs1, f3, rd, opc} = in_inst;
    assign rf_raddr = {rs2, rs1};
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'h000};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    always_comb begin
        imm = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        wcls = 1'b0;
        legal = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC: begin imm = imm_u; wcls = 1'b1; legal = 1'b1; end
            OP_JAL:   begin imm = imm_j; wcls = 1'b1; legal = 1'b1; end
            OP_JALR:  begin imm = imm_i; use1 = 1'b1; wcls = 1'b1; legal = f3 == 3'd0; end
            OP_BR:    begin imm = imm_b; use1 = 1'b1; use2 = 1'b1; legal = f3[2:1] != 2'b01; end
            OP_LOAD:  begin imm = imm_i; use1 = 1'b1; wcls = 1'b1; legal = f3 != 3'd3 && f3 < 3'd6; end
            OP_STORE: begin imm = imm_s; use1 = 1'b1; use2 = 1'b1; legal = f3 < 3'd3; end
            OP_IMM:   begin
                imm = imm_i;
                use1 = 1'b1;
                wcls = 1'b1;
                legal = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            end
            OP_OP:    begin
                use1 = 1'b1;
                use2 = 1'b1;
                wcls = 1'b1;
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            OP_FENCE: begin imm = imm_i; legal = f3 == 3'd0; end
            OP_SYS:   begin imm = imm_i; legal = in_inst == 32'h0000_0073 || in_inst == 32'h0010_0073; end
            default: ;
        endcase
    end
    // Scan from oldest to youngest so the youngest matching source overrides.
    always_comb begin
        op1 = rf_rdata[31:0];
        op2 = rf_rdata[63:32];
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs1) begin op1 = fwd_data[32*i +: 32]; p1 = fwd_pending[i]; end
            if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs2) begin op2 = fwd_data[32*i +: 32]; p2 = fwd_pending[i]; end
        end
        if (!use1 || rs1 == 5'd0) begin op1 = '0; p1 = 1'b0; end
        if (!use2 || rs2 == 5'd0) begin op2 = '0; p2 = 1'b0; end
    end
    assign hazard = p1 || p2;
    assign wreg = legal && wcls && rd != 5'd0;
    assign cond = f3[2:1] == 2'b00 ? op1 == op2 : f3[2:1] == 2'b10 ? $signed(op1) < $signed(op2) : op1 < op2;
    assign taken = legal && (opc == OP_JAL || opc == OP_JALR || (opc == OP_BR && (cond ^ f3[0])));
    assign target = opc == OP_JALR ? (op1 + imm) & ~32'd1 : in_pc + imm;
    assign kill = state == KILL;
    assign in_ready = !rst && !flush_i && (kill || (!hazard && (state == EMPTY || out_ready)));
    assign accept = in_valid && in_ready && !kill;
    assign out_valid = state != EMPTY;
    assign br_valid = kill;
    always_comb begin
        state_nxt = flush_i ? EMPTY : accept ? (taken ? KILL : FULL) : (state == EMPTY || out_ready) ? EMPTY : FULL;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc <= '0;
            out_inst <= '0;
            out_imm <= '0;
            out_op1 <= '0;
            out_op2 <= '0;
            out_rd <= '0;
            out_wreg <= 1'b0;
            out_illegal <= 1'b0;
            br_target <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                out_pc <= in_pc;
                out_inst <= in_inst;
                out_imm <= imm;
                out_op1 <= op1;
                out_op2 <= op2;
                out_rd <= wreg ? rd : 5'd0;
                out_wreg <= wreg;
                out_illegal <= !legal;
            end
            if (accept && taken) br_target <= target;
            if (in_valid && hazard && !flush_i && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed corner sequences and a randomized reference model
module tb_decode_stage;
    localparam int NF = 2;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, flush_i, out_valid, out_ready, out_wreg, out_illegal, br_valid;
    logic [31:0] in_pc, in_inst, out_pc, out_inst, out_imm, out_op1, out_op2, br_target;
    logic [9:0] rf_raddr;
    logic [63:0] rf_rdata;
    logic [NF-1:0] fwd_valid, fwd_pending;
    logic [5*NF-1:0] fwd_rd;
    logic [32*NF-1:0] fwd_data;
    logic [4:0] out_rd;
    logic [CW-1:0] stall_cnt;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst, pc;
        logic [63:0] rf;
        logic [31:0] imm, op1, op2;
        logic [4:0] rd;
        logic wreg, ill, br;
        logic [31:0] tgt;
    } vec_t;
    typedef struct {
        logic [31:0] pc, inst, imm, op1, op2, tgt;
        logic [4:0] rd;
        logic wreg, taken;
    } rec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    decode_stage #(.NUM_FWD(NF), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst(in_inst), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid),
        .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush_i(flush_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
        .out_wreg(out_wreg), .out_illegal(out_illegal), .br_valid(br_valid),
        .br_target(br_target), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush_i = 1'b0;
        out_ready = 1'b1;
        fwd_valid = '0;
        fwd_pending = '0;
        fwd_rd = '0;
        fwd_data = '0;
        rf_rdata = '0;
        in_inst = '0;
        in_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic offer_hazard();
        fwd_valid = 2'b01;
        fwd_pending = 2'b01;
        fwd_rd = {5'd0, 5'd5};
        fwd_data = {32'd0, 32'h1234};
        in_valid = 1'b1;
        in_inst = 32'h0052_8333;
        in_pc = 32'h10;
    endtask

    function automatic logic [32:0] resolve(input logic [4:0] rs, input bit used, input logic [31:0] rfv);
        if (!used || rs == 5'd0) return 33'd0;
        for (int i = 0; i < NF; i++)
            if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs) return {fwd_pending[i], fwd_data[32*i +: 32]};
        return {1'b0, rfv};
    endfunction

    function automatic bit br_cond(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return $signed(x) < $signed(y);
            3'd5: return $signed(x) >= $signed(y);
            3'd6: return x < y;
            default: return x >= y;
        endcase
    endfunction

    function automatic logic [31:0] enc(input int kind, input logic [4:0] rd, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f, input logic [31:0] v, input bit sub);
        case (kind)
            0: return {sub ? 7'h20 : 7'h00, s2, s1, 3'd0, rd, 7'h33};
            1: return {v[11:0], s1, 3'd0, rd, 7'h13};
            2: return {v[31:12], rd, 7'h37};
            3: return {v[12], v[10:5], s2, s1, f, v[4:1], v[11], 7'h63};
            4: return {v[20], v[10:1], v[11], v[19:12], rd, 7'h6f};
            5: return {v[11:0], s1, 3'd0, rd, 7'h67};
            6: return {v[11:0], s1, 3'd2, rd, 7'h03};
            default: return {v[11:5], s2, s1, 3'd2, v[4:0], 7'h23};
        endcase
    endfunction

    int kind, cnt;
    logic [4:0] g_rd, g_rs1, g_rs2;
    logic [2:0] bf;
    logic [2:0] brf[6];
    logic [31:0] r, imm;
    logic [32:0] a, b;
    bit hz, rdy, acc, mv, mk;
    rec_t e, held;

    initial begin
        tbl[0]  = '{32'hFFF00093, 32'h000, 64'h5_0000_0009, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{32'h00528333, 32'h004, 64'h22_0000_0011, 32'h0, 32'h11, 32'h22, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{32'h00208463, 32'h100, 64'h7_0000_0007, 32'h8, 32'h7, 32'h7, 5'd0, 1'b0, 1'b0, 1'b1, 32'h108};
        tbl[3]  = '{32'h00208463, 32'h100, 64'h8_0000_0007, 32'h8, 32'h7, 32'h8, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{32'h007100E7, 32'h040, 64'h99_0000_0200, 32'h7, 32'h200, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 32'h206};
        tbl[5]  = '{32'h123451B7, 32'h008, 64'h1_0000_0002, 32'h12345000, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{32'hFFDFF06F, 32'h020, 64'h1_0000_0002, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1C};
        tbl[7]  = '{32'hFE532E23, 32'h000, 64'hAA_0000_00BB, 32'hFFFFFFFC, 32'hBB, 32'hAA, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{32'hFFFFFFFF, 32'h000, 64'h1_0000_0002, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{32'h40529333, 32'h000, 64'h22_0000_0011, 32'h0, 32'h11, 32'h22, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{32'h0020C463, 32'h100, 64'h1_FFFF_FFFF, 32'h8, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h108};
        tbl[11] = '{32'h0020E463, 32'h100, 64'h1_FFFF_FFFF, 32'h8, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        // reset state, with an instruction offered throughout
        do_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_br_valid", br_valid, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        rst = 1'b0;
        in_valid = 1'b0;

        // load-use stall then forwarded release
        do_reset();
        offer_hazard();
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("stall_cnt3", stall_cnt, 3);
        chk("stall_out_valid", out_valid, 1'b0);
        fwd_pending = '0;
        @(negedge clk);
        chk("fwd_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fwd_valid = '0;
        chk("fwd_op1", out_op1, 32'h1234);
        chk("fwd_op2", out_op2, 32'h1234);
        chk("fwd_out_valid", out_valid, 1'b1);
        chk("fwd_stall_hold", stall_cnt, 3);

        // decode vector table
        do_reset();
        foreach (tbl[k]) begin
            in_valid = 1'b1;
            in_inst = tbl[k].inst;
            in_pc = tbl[k].pc;
            rf_rdata = tbl[k].rf;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", k), in_ready, 1'b1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_out_valid", k), out_valid, 1'b1);
            chk($sformatf("tbl%0d_pc", k), out_pc, tbl[k].pc);
            chk($sformatf("tbl%0d_inst", k), out_inst, tbl[k].inst);
            chk($sformatf("tbl%0d_imm", k), out_imm, tbl[k].imm);
            chk($sformatf("tbl%0d_op1", k), out_op1, tbl[k].op1);
            chk($sformatf("tbl%0d_op2", k), out_op2, tbl[k].op2);
            chk($sformatf("tbl%0d_rd", k), out_rd, tbl[k].rd);
            chk($sformatf("tbl%0d_wreg", k), out_wreg, tbl[k].wreg);
            chk($sformatf("tbl%0d_illegal", k), out_illegal, tbl[k].ill);
            chk($sformatf("tbl%0d_br_valid", k), br_valid, tbl[k].br);
            if (tbl[k].br) chk($sformatf("tbl%0d_br_target", k), br_target, tbl[k].tgt);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_br_pulse_end", k), br_valid, 1'b0);
        end

        // taken branch: the instruction offered in the redirect cycle is discarded
        do_reset();
        in_valid = 1'b1;
        in_inst = 32'h0020_8463;
        in_pc = 32'h100;
        rf_rdata = 64'h7_0000_0007;
        @(posedge clk);
        #1;
        chk("kill_br_valid", br_valid, 1'b1);
        chk("kill_br_target", br_target, 32'h108);
        in_inst = 32'hFFF0_0093;
        in_pc = 32'h200;
        @(negedge clk);
        chk("kill_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("kill_br_drop", br_valid, 1'b0);
        chk("kill_out_valid", out_valid, 1'b0);
        chk("kill_out_pc", out_pc, 32'h100);

        // back-pressure stability, flush, then reset during a stall
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_inst = 32'h1234_51B7;
        in_pc = 32'h40;
        @(posedge clk);
        #1;
        chk("bp_out_valid", out_valid, 1'b1);
        in_inst = 32'hFFF0_0093;
        in_pc = 32'h44;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            chk("bp_out_pc", out_pc, 32'h40);
            chk("bp_out_imm", out_imm, 32'h1234_5000);
            chk("bp_out_valid_hold", out_valid, 1'b1);
        end
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_br_valid", br_valid, 1'b0);
        in_inst = 32'h1234_51B7;
        in_pc = 32'h80;
        @(posedge clk);
        #1;
        offer_hazard();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_stall_pre", stall_cnt, 2);
        chk("midrst_held", out_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_stall_cnt", stall_cnt, 0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_pc", out_pc, 0);

        // stall counter saturation
        do_reset();
        offer_hazard();
        repeat (17) @(posedge clk);
        #1;
        chk("stall_saturate", stall_cnt, 15);

        // randomized traffic against the reference model
        do_reset();
        mv = 0;
        mk = 0;
        cnt = 0;
        for (int c = 0; c < 2500; c++) begin
            kind = $urandom_range(0, 7);
            g_rd = 5'($urandom_range(0, 7));
            g_rs1 = 5'($urandom_range(0, 7));
            g_rs2 = 5'($urandom_range(0, 7));
            bf = brf[$urandom_range(0, 5)];
            r = $urandom();
            case (kind)
                0: imm = 32'd0;
                2: imm = {r[19:0], 12'h000};
                3: imm = {{19{r[12]}}, r[12:1], 1'b0};
                4: imm = {{11{r[20]}}, r[20:1], 1'b0};
                default: imm = {{20{r[11]}}, r[11:0]};
            endcase
            in_inst = enc(kind, g_rd, g_rs1, g_rs2, bf, imm, r[31]);
            in_pc = $urandom() & 32'hFFFF_FFFC;
            in_valid = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 7;
            flush_i = $urandom_range(0, 19) == 0;
            fwd_valid = NF'($urandom());
            for (int i = 0; i < NF; i++) begin
                fwd_pending[i] = $urandom_range(0, 3) == 0;
                fwd_rd[5*i +: 5] = 5'($urandom_range(0, 7));
                fwd_data[32*i +: 32] = $urandom();
            end
            rf_rdata = {$urandom(), $urandom()};
            a = resolve(g_rs1, kind inside {0, 1, 3, 5, 6, 7}, rf_rdata[31:0]);
            b = resolve(g_rs2, kind inside {0, 3, 7}, rf_rdata[63:32]);
            hz = a[32] || b[32];
            rdy = flush_i ? 1'b0 : mk ? 1'b1 : (!hz && (!mv || out_ready));
            acc = in_valid && rdy && !mk;
            e.pc = in_pc;
            e.inst = in_inst;
            e.imm = imm;
            e.op1 = a[31:0];
            e.op2 = b[31:0];
            e.wreg = kind inside {0, 1, 2, 4, 5, 6} && g_rd != 5'd0;
            e.rd = e.wreg ? g_rd : 5'd0;
            e.taken = kind == 4 || kind == 5 || (kind == 3 && br_cond(bf, a[31:0], b[31:0]));
            e.tgt = kind == 5 ? (a[31:0] + imm) & 32'hFFFF_FFFE : in_pc + imm;
            @(negedge clk);
            chk("rnd_in_ready", in_ready, rdy);
            if (kind inside {0, 3, 7}) chk("rnd_rf_raddr", rf_raddr, {g_rs2, g_rs1});
            @(posedge clk);
            #1;
            if (in_valid && hz && !flush_i && cnt < 15) cnt++;
            if (flush_i) begin
                mv = 0;
                mk = 0;
            end else if (acc) begin
                mv = 1;
                mk = e.taken;
                held = e;
            end else begin
                mv = mv && !out_ready;
                mk = 0;
            end
            chk("rnd_out_valid", out_valid, mv);
            chk("rnd_br_valid", br_valid, mk);
            chk("rnd_stall_cnt", stall_cnt, 32'(cnt));
            if (mv) begin
                chk("rnd_pc", out_pc, held.pc);
                chk("rnd_inst", out_inst, held.inst);
                chk("rnd_imm", out_imm, held.imm);
                chk("rnd_op1", out_op1, held.op1);
                chk("rnd_op2", out_op2, held.op2);
                chk("rnd_rd", out_rd, held.rd);
                chk("rnd_wreg", out_wreg, held.wreg);
                chk("rnd_illegal", out_illegal, 1'b0);
            end
            if (mk) chk("rnd_br_target", br_target, held.tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter NUM_FWD, default 2: number of forwarding sources; index 0 is youngest and has highest priority.
REQ-002 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-003 SHALL have port clk  in  1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  in  1: fetch offers in_pc/in_inst.
REQ-006 SHALL have port in_ready  out  1: instruction accepted this cycle when in_valid && in_ready.
REQ-007 SHALL have port in_pc  in  32: instruction address.
REQ-008 SHALL have port in_inst  in  32: RV32I instruction word.
REQ-009 SHALL have port rf_raddr  out  10: {rs2, rs1} of in_inst, driven combinationally.
REQ-010 SHALL have port rf_rdata  in  64: {rs2 value, rs1 value}, same-cycle regfile read.
REQ-011 SHALL have port fwd_valid  in  NUM_FWD: source i will write fwd_rd[i].
REQ-012 SHALL have port fwd_pending  in  NUM_FWD: source i data not yet available (load in flight).
REQ-013 SHALL have port fwd_rd  in  5*NUM_FWD: destination register per source.
REQ-014 SHALL have port fwd_data  in  32*NUM_FWD: write data per source.
REQ-015 SHALL have port flush_i  in  1: downstream redirect; kills held and offered instruction.
REQ-016 SHALL have port out_valid  out  1: output register holds a decoded instruction.
REQ-017 SHALL have port out_ready  in  1: execute consumes when out_valid && out_ready.
REQ-018 SHALL have port out_pc  out  32: registered in_pc.
REQ-019 SHALL have port out_inst  out  32: registered in_inst.
REQ-020 SHALL have port out_imm  out  32: sign-extended immediate (I/S/B/U/J per opcode, 0 for R-type).
REQ-021 SHALL have port out_op1  out  32: resolved rs1 value.
REQ-022 SHALL have port out_op2  out  32: resolved rs2 value.
REQ-023 SHALL have port out_rd  out  5: destination; 0 when out_wreg=0.
REQ-024 SHALL have port out_wreg  out  1: register write enable (LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, rd!=0).
REQ-025 SHALL have port out_illegal  out  1: opcode/funct not RV32I base; forces out_wreg=0.
REQ-026 SHALL have port br_valid  out  1: one-cycle redirect pulse.
REQ-027 SHALL have port br_target  out  32: redirect address, valid with br_valid.
REQ-028 SHALL have port stall_cnt  out  CNT_W: hazard stall cycles, saturating.

Function
REQ-029 SHALL resolve each operand: x0 -> 0; else lowest i with fwd_valid[i] && fwd_rd[i]==rs -> fwd_data[i]; else rf_rdata; unused operand -> 0.
REQ-030 SHALL flag hazard when a used rs!=0 matches a source whose highest-priority match has fwd_pending=1.
REQ-031 SHALL drive in_ready = !flush_i && !hazard && (!out_valid || out_ready), except during kill cycle (REQ-035).
REQ-032 SHALL load output register on acceptance, one-cycle latency; out_valid cleared when consumed with no acceptance; fields stable while out_valid && !out_ready.
REQ-033 SHALL resolve control flow at acceptance: JAL target pc+immJ; JALR (op1+immI)&~1; branches BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned, taken -> pc+immB; all 32-bit wrap-around.
REQ-034 SHALL register br_valid/br_target for exactly one cycle after accepting a taken branch or jump.
REQ-035 SHALL treat the br_valid cycle as kill: in_ready=1, offered instruction discarded, out_valid unchanged by it.
REQ-036 SHALL give flush_i priority over everything: next cycle out_valid=0, br_valid=0, no acceptance.
REQ-037 SHALL increment stall_cnt each cycle in_valid && hazard && !flush_i, holding at 2^CNT_W-1.
REQ-038 SHALL use an FSM EMPTY/FULL/KILL: EMPTY->FULL on accept; FULL->EMPTY on consume without accept; any->KILL on taken accept; KILL->FULL/EMPTY per out_valid next cycle; flush -> EMPTY.

Reset
REQ-039 SHALL on rst clear out_valid, br_valid, stall_cnt and all out_* fields to 0 and enter EMPTY.
REQ-040 SHALL drop any held or stalled instruction when rst asserts mid-operation; in_ready=0 while rst high.

Verification
REQ-041 SHALL cover: in_inst=0xFFF00093 (addi x1,x0,-1) pc=0 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=1, out_wreg=1, out_op1=0.
REQ-042 SHALL cover: fwd[0] rd=5 pending=1, add x6,x5,x5 offered 3 cycles -> in_ready=0, stall_cnt=3; pending drops, data=0x1234 -> accepted, out_op1=out_op2=0x1234.
REQ-043 SHALL cover: beq x1,x2,+8 at pc 0x100, both 7 -> br_valid one cycle, br_target=0x108; instruction offered that cycle discarded.
REQ-044 SHALL cover: jalr x1,7(x2), x2=0x200 -> br_target=0x206, out_wreg=1, out_rd=1.
REQ-045 SHALL cover: out_ready=0 for 4 cycles -> outputs stable, in_ready=0; flush_i -> out_valid=0 next cycle; rst mid-stall -> stall_cnt=0, out_valid=0.
